// File: rtl/mem_arb_pkg.sv
// Shared owner encoding and starvation-counter sizing for the memory port arbiter.
// Used by the arbiter, its priority picker and bench monitors.
// No ports; constants and types only.
package mem_arb_pkg;

   typedef logic [1:0] owner_t;

   localparam owner_t OWN_NONE  = 2'd0;
   localparam owner_t OWN_HOST  = 2'd1;
   localparam owner_t OWN_DATA  = 2'd2;
   localparam owner_t OWN_FETCH = 2'd3;

   // Largest legal STARVE_MAX; the counter is sized to hold it.
   localparam int STARVE_LIMIT = 15;
   localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes (host, data, fetch) plus the single memory port.
// slave : arbiter side (takes requests, drives grants/responses and mem_*).
// master: requester/memory side (drives requests and mem_rdata).
interface mem_port_arbiter_if #(
   parameter int AW = 16
);
   logic          host_lock;

   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_addr;
   logic [31:0]   h_wdata;
   logic [3:0]    h_wstrb;
   logic          h_gnt;
   logic          h_rvalid;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [3:0]    d_wstrb;
   logic          d_gnt;
   logic          d_rvalid;

   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;

   logic [31:0]   rdata;

   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  host_lock,
      input  h_req, h_we, h_addr, h_wdata, h_wstrb,
      output h_gnt, h_rvalid,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      output d_gnt, d_rvalid,
      input  i_req, i_addr,
      output i_gnt, i_rvalid,
      output rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output host_lock,
      output h_req, h_we, h_addr, h_wdata, h_wstrb,
      input  h_gnt, h_rvalid,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  d_gnt, d_rvalid,
      output i_req, i_addr,
      input  i_gnt, i_rvalid,
      input  rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: host > data > fetch, fetch forced once starved.
// Ports: rst_n_i (low forces no winner), host_lock_i, *_req_i, starve_cnt_i -> winner_o.
// Zero latency; no state.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                rst_n_i,
   input  logic                host_lock_i,
   input  logic                h_req_i,
   input  logic                d_req_i,
   input  logic                i_req_i,
   input  logic [STARVE_W-1:0] starve_cnt_i,
   output owner_t              winner_o
);

   logic fetch_ok;
   logic starved;

   assign fetch_ok = i_req_i && !host_lock_i;
   assign starved  = (starve_cnt_i == STARVE_W'(STARVE_MAX));

   always_comb begin
      winner_o = OWN_NONE;
      if (!rst_n_i) begin
         winner_o = OWN_NONE;
      end else if (starved && fetch_ok) begin
         // Override sits above the host so a starved fetch cannot be delayed further.
         winner_o = OWN_FETCH;
      end else if (h_req_i) begin
         winner_o = OWN_HOST;
      end else if (d_req_i && !host_lock_i) begin
         winner_o = OWN_DATA;
      end else if (fetch_ok) begin
         winner_o = OWN_FETCH;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between host, data and fetch; one grant per cycle.
// Ports: clk, rst (sync active-low), bus (slave modport: requests, grants, responses, mem_*).
// Grant is same-cycle; response is one cycle after grant with rdata = mem_rdata.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   owner_t              winner;
   owner_t              owner_q, owner_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

   logic [AW-1:0]       addr_sel;
   logic [31:0]         wdata_sel;
   logic [3:0]          we_sel;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .rst_n_i      (rst),
      .host_lock_i  (bus.host_lock),
      .h_req_i      (bus.h_req),
      .d_req_i      (bus.d_req),
      .i_req_i      (bus.i_req),
      .starve_cnt_i (starve_cnt_q),
      .winner_o     (winner)
   );

   // Request mux onto the memory port; idle cycles park everything at zero.
   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      we_sel    = '0;
      case (winner)
         OWN_HOST: begin
            addr_sel  = bus.h_addr;
            wdata_sel = bus.h_wdata;
            we_sel    = bus.h_we ? bus.h_wstrb : 4'b0000;
         end
         OWN_DATA: begin
            addr_sel  = bus.d_addr;
            wdata_sel = bus.d_wdata;
            we_sel    = bus.d_we ? bus.d_wstrb : 4'b0000;
         end
         OWN_FETCH: begin
            addr_sel  = bus.i_addr;
         end
         OWN_NONE: begin
            addr_sel  = '0;
         end
      endcase
   end

   assign bus.h_gnt     = (winner == OWN_HOST);
   assign bus.d_gnt     = (winner == OWN_DATA);
   assign bus.i_gnt     = (winner == OWN_FETCH);
   assign bus.mem_en    = (winner != OWN_NONE);
   assign bus.mem_we    = we_sel;
   assign bus.mem_addr  = addr_sel;
   assign bus.mem_wdata = wdata_sel;

   // Responses follow the owner registered at grant time; holding reset low
   // suppresses any response still in flight.
   assign bus.h_rvalid  = rst && (owner_q == OWN_HOST);
   assign bus.d_rvalid  = rst && (owner_q == OWN_DATA);
   assign bus.i_rvalid  = rst && (owner_q == OWN_FETCH);
   assign bus.rdata     = bus.mem_rdata;

   always_comb begin
      owner_d      = winner;
      starve_cnt_d = starve_cnt_q;
      // Only a fetch that is eligible yet loses builds starvation credit.
      if (!bus.i_req || bus.host_lock || (winner == OWN_FETCH)) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < STARVE_W'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q      <= OWN_NONE;
         starve_cnt_q <= '0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule
